uart_rx_8n1: RTL and testbench



---
 rtl/uart_rx_8n1.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 -- 8N1 UART receiver, oversampling the raw rx pin from the
// system clock. The receive-side counterpart of uart_tx_8n1.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   undefined : one sample per bit at the nominal mid-bit point.
//   defined   : three samples (nominal -1, 0, +1) with a majority vote. The
//               decision lands one cycle later, so rx_valid / frame_err move
//               by +1 cycle. Needs CLKS_PER_BIT >= 4.
//
// Ports:
//   clk       in   system clock (12 MHz internal oscillator)
//   rst       in   synchronous reset, active-high
//   rx        in   asynchronous serial line, idles high
//   rxbyte    out  [7:0] last correctly framed byte, LSB received first
//   rx_valid  out  one-cycle pulse when rxbyte has been updated
//   frame_err out  one-cycle pulse when the stop bit samples low
//   busy      out  high in any state other than IDLE
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT) + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_DLY  = 1;
`else
  localparam int DEC_DLY  = 0;
`endif
  // Only the start decision needs the extra cycle; every later decision is
  // a full bit period after the previous one, so the delay carries through.
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT - 1 + DEC_DLY);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             w_rx_s;
  logic             w_bit;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitidx;
  logic [7:0]       r_shreg;
  logic             w_tick;
  logic             w_shift;
  logic             w_valid_nxt;
  logic             w_ferr_nxt;

  // Input synchronizer: everything downstream looks only at w_rx_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic r_hist1;
  logic r_hist2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // At the decision cycle (nominal+1): r_hist2 = nominal-1, r_hist1 = nominal,
  // w_rx_s = nominal+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist1 <= 1'b1;
      r_hist2 <= 1'b1;
    end else begin
      r_hist1 <= w_rx_s;
      r_hist2 <= r_hist1;
    end
  end

  assign w_bit = maj3(r_hist2, r_hist1, w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_rx_s) w_state_nxt = S_START;
      S_START: if (w_tick) w_state_nxt = w_bit ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick && (r_bitidx == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_tick) w_state_nxt = w_bit ? S_IDLE : S_BREAK;
      S_BREAK: if (w_rx_s) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_tick      = 1'b0;
    w_shift     = 1'b0;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_START: w_tick = (r_cnt == START_LAST);
      S_DATA: begin
        w_tick  = (r_cnt == BIT_LAST);
        w_shift = w_tick;
      end
      S_STOP: begin
        w_tick      = (r_cnt == BIT_LAST);
        w_valid_nxt = w_tick & w_bit;
        w_ferr_nxt  = w_tick & ~w_bit;
      end
      default: ;
    endcase
  end

  // Counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bitidx  <= 3'd0;
      r_shreg   <= 8'h00;
      rxbyte    <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_tick || (r_state == S_IDLE) || (r_state == S_BREAK)) r_cnt <= '0;
      else                                                       r_cnt <= r_cnt + CNT_W'(1);

      // LSB arrives first, so shifting right leaves bit 0 in r_shreg[0].
      if (w_shift) begin
        r_shreg  <= {w_bit, r_shreg[7:1]};
        r_bitidx <= r_bitidx + 3'd1;
      end else if (r_state != S_DATA) begin
        r_bitidx <= 3'd0;
      end

      if (w_valid_nxt) rxbyte <= r_shreg;
      rx_valid  <= w_valid_nxt;
      frame_err <= w_ferr_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
module tb_uart_rx_8n1;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rxbyte;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int v_last = 0;
  int v_prev = 0;

  // Scoreboard entries: {is_frame_err, byte}
  logic [8:0] sb[$];

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rxbyte   (rxbyte),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else             n_pass++;
  endtask

  // Pulse monitor: pops one scoreboard entry per rx_valid/frame_err pulse.
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;
  logic [8:0] e;
  always @(negedge clk) begin
    if (prev_v) chk("valid_width", rx_valid, 1'b0);
    if (prev_e) chk("ferr_width", frame_err, 1'b0);
    if (rx_valid || frame_err) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {frame_err, rx_valid}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {frame_err, rx_valid}, {e[8], ~e[8]});
        if (!e[8]) chk("rxbyte", rxbyte, e[7:0]);
      end
    end
    if (rx_valid) begin
      v_prev = v_last;
      v_last = cyc;
    end
    prev_v = rx_valid;
    prev_e = frame_err;
  end

  // Drives up to ncyc cycles of a frame: start, 8 data bits LSB first, stop.
  // gmask[j] inverts rx for the one cycle at the nominal sample point of
  // bit period j (0 = start, 1..8 = data, 9 = stop).
  task automatic drive_frame(input logic [7:0] b, input logic stopv,
                             input logic [9:0] gmask, input int ncyc);
    logic [9:0] bits;
    int n;
    bits = {stopv, b, 1'b0};
    n = 0;
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < CPB; c++) begin
        if (n < ncyc) begin
          rx = bits[j] ^ (gmask[j] && (c == HALF));
          @(posedge clk); #1;
          n++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rxbyte", rxbyte, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);

    // Single frame 0xA5
    sb.push_back({1'b0, 8'hA5});
    fork
      drive_frame(8'hA5, 1'b1, 10'h000, 10 * CPB);
      begin
        repeat (80) @(negedge clk);
        chk("busy_mid_a5", busy, 1'b1);
      end
    join
    idle(20);
    chk("busy_after_a5", busy, 1'b0);
    chk("sb_after_a5", sb.size(), 0);

    // Back-to-back 0x00 then 0xFF, no idle gap
    sb.push_back({1'b0, 8'h00});
    sb.push_back({1'b0, 8'hFF});
    drive_frame(8'h00, 1'b1, 10'h000, 10 * CPB);
    drive_frame(8'hFF, 1'b1, 10'h000, 10 * CPB);
    idle(20);
    chk("b2b_spacing", v_last - v_prev, 160);
    chk("sb_after_b2b", sb.size(), 0);

    // 0x3C with a low stop bit, then the line held low for 40 bit times
    sb.push_back({1'b1, 8'h00});
    drive_frame(8'h3C, 1'b0, 10'h000, 10 * CPB);
    rx = 1'b0;
    repeat (40 * CPB) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("busy_break", busy, 1'b1);
    chk("rxbyte_kept_ferr", rxbyte, 8'hFF);
    idle(20);
    chk("busy_after_break", busy, 1'b0);
    chk("sb_after_ferr", sb.size(), 0);

    // 3-cycle low glitch on an idle line
    rx = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rx = 1'b1;
    @(negedge clk);
    chk("busy_glitch_start", busy, 1'b1);
    idle(30);
    chk("busy_after_glitch", busy, 1'b0);
    chk("rxbyte_kept_glitch", rxbyte, 8'hFF);

    // Reset in the middle of data bit 4 of 0x5A; the transmitter abandons
    // the frame at that point and the line returns to idle.
    drive_frame(8'h5A, 1'b1, 10'h000, 5 * CPB + 5);
    rx  = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rxbyte", rxbyte, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", rx_valid, 1'b0);
    idle(20);
    sb.push_back({1'b0, 8'h81});
    drive_frame(8'h81, 1'b1, 10'h000, 10 * CPB);
    idle(20);
    chk("rxbyte_81", rxbyte, 8'h81);

    // One-cycle inverted glitches at the nominal sample points
`ifdef UART_RX_MAJORITY_EN
    sb.push_back({1'b0, 8'hC3});
    drive_frame(8'hC3, 1'b1, 10'h3FF, 10 * CPB);
    idle(20);
    chk("glitch_vote", rxbyte, 8'hC3);
`else
    // Single sampling: every data bit is read inverted, start/stop clean.
    sb.push_back({1'b0, 8'h3C});
    drive_frame(8'hC3, 1'b1, 10'h1FE, 10 * CPB);
    idle(20);
    chk("glitch_single", rxbyte, 8'h3C);
`endif

    idle(10);
    chk("sb_final", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
